lsu_mem_req: RTL
================

Name: lsu_mem_req

Overview:
- Load/store request sequencer directly upstream of the DPI-backed memory controller.
- Accepts one load/store from the execute stage over a valid/ready handshake and checks alignment.
- Generates the word-aligned address, byte-lane write mask and lane-shifted write data, then pulses the memory controller's valid for exactly one cycle after a programmable wait.
- Extracts and sign/zero-extends load data and returns a response over a second valid/ready handshake; provides a deterministic memory-latency model for the core.

Parameters:
- LATENCY, 0, number of wait cycles inserted between request accept and the memory access cycle (0..255).

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_wen  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or reserved-size request
- mem_valid  output  1  to memory controller valid
- mem_raddr  output  32  word-aligned address, {addr[31:2],2'b00}
- mem_wen  output  1  to memory controller wen
- mem_waddr  output  32  same value as mem_raddr
- mem_wdata  output  32  lane-shifted store data
- mem_wmask  output  8  byte-lane mask; bits [7:4] always 0
- mem_rdata  input  32  word returned by memory controller, combinational in the same cycle

Behaviour:
- FSM states: IDLE, WAIT, ACCESS, RESP.
- Reset (asynchronous, active-low):
  - state = IDLE; wait counter = 0; latched request fields = 0.
  - Outputs: req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_valid = 0, mem_wen = 0, mem_wmask = 0.
  - A reset mid-transaction aborts it; no mem_valid pulse follows the reset.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch wen, addr, wdata, size and unsigned.
  - Misaligned or reserved request goes to RESP with err = 1. Misaligned means size = 1 with addr[0] = 1, size = 2 with addr[1:0] != 0, or size = 3.
  - Otherwise go to WAIT when LATENCY > 0 (counter cleared), or to ACCESS when LATENCY = 0.
- WAIT:
  - Counter increments each cycle.
  - Go to ACCESS in the cycle the counter reaches LATENCY-1; WAIT therefore lasts exactly LATENCY cycles.
- ACCESS:
  - Lasts exactly one cycle: mem_valid = 1, mem_wen = latched wen.
  - Address, mask and data are driven only in this cycle; all mem_* outputs are 0 outside ACCESS.
  - Loads capture mem_rdata at the end of this cycle.
  - Always go to RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready, go to IDLE.
  - req_ready = 0 in WAIT, ACCESS and RESP; there is no request/response overlap. A new request is accepted at the earliest in the cycle after the handshake.
- Latency:
  - Valid request accepted at edge 0: resp_valid first high in cycle LATENCY+2.
  - Error request: resp_valid high in cycle 1, and there is never a mem_valid pulse.
- Lane rules, with off = addr[1:0]:
  - wmask: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111.
  - mem_wdata = req_wdata << (8*off); upper bits are shifted out.
  - Load: sh = mem_rdata >> (8*off). Byte takes sh[7:0]; half takes sh[15:0]; word takes sh[31:0].
  - Load extension: sign-extended from the top bit unless unsigned; unsigned for size 2 has no effect.
  - Loads drive wmask = 0 and wen = 0.
- resp_rdata = 0 for stores and for errors.
- Ignored inputs: req_* inputs are ignored outside IDLE, and resp_ready is ignored outside RESP.

Test Plan:
- Reset, then LATENCY=0: load word addr 0x80000004, mem_rdata=0xDEADBEEF → mem_valid high for one cycle with mem_raddr=0x80000004; resp_valid in cycle 2; resp_rdata=0xDEADBEEF, err=0.
- Signed byte load addr 0x80000003, mem_rdata=0x80FF0000 → resp_rdata=0xFFFFFF80. Same request with unsigned → 0x00000080.
- Half store addr 0x80000002, wdata=0x1234ABCD → mem_wen=1, mem_waddr=0x80000000, mem_wmask=0x0C, mem_wdata=0xABCD0000; resp_rdata=0.
- Misaligned word load addr 0x80000001 → no mem_valid pulse; resp_valid in cycle 1 with err=1, rdata=0. Same for size=3.
- LATENCY=3, resp_ready held 0 for 4 cycles → mem_valid in cycle 4, resp_valid from cycle 5 with stable data, req_ready=0 throughout. A req_valid presented meanwhile is not accepted until after the response handshake.
- Reset asserted in WAIT (LATENCY=5, cycle 2) → all outputs return to reset values immediately, no mem_valid pulse, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_mem_req.sv
// rtl/lsu_mem_req.sv - load/store request sequencer in front of the memory controller
//
// Accepts one load/store over req_valid/req_ready and checks its alignment.
// It then waits LATENCY cycles and drives a single-cycle access to the memory
// controller. The response goes back over resp_valid/resp_ready.
//
// Ports:
//   clock, reset                 clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_wen, req_addr, req_wdata request fields (store data right-justified)
//   req_size, req_unsigned       access size (0 byte, 1 half, 2 word, 3 reserved), load extension
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_err         extended load data, misaligned/reserved flag
//   mem_valid, mem_wen           one-cycle access strobe and write enable
//   mem_raddr, mem_waddr         word-aligned address (identical values)
//   mem_wdata, mem_wmask         lane-shifted store data, byte-lane mask ([7:4] unused)
//   mem_rdata                    word from the memory controller, valid during the access cycle

module lsu_mem_req #(
    parameter int unsigned LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic [31:0] mem_raddr,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Terminal count of the wait counter; unused when LATENCY is 0 because
    // WAIT is then never entered.
    localparam logic [7:0] LAST_CNT = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);
    localparam bit         NO_WAIT  = (LATENCY == 0);

    state_t      state, state_n;
    logic [7:0]  cnt;

    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        req_bad;
    logic        accept;
    logic [4:0]  shamt;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] rd_shifted;
    logic [31:0] ld_ext;
    logic [31:0] word_addr;

    // Alignment check on the incoming request (size 3 is always rejected).
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'd0:    req_bad = 1'b0;
            2'd1:    req_bad = req_addr[0];
            2'd2:    req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    assign accept = (state == S_IDLE) && req_valid;

    // Lane steering uses the latched request so the access cycle is stable
    // regardless of what the execute stage drives meanwhile.
    assign shamt     = {addr_q[1:0], 3'b000};
    assign word_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        lane_mask = 4'b0000;
        case (size_q)
            2'd0:    lane_mask = 4'b0001 << addr_q[1:0];
            2'd1:    lane_mask = 4'b0011 << addr_q[1:0];
            2'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    assign lane_wdata = wdata_q << shamt;
    assign rd_shifted = mem_rdata >> shamt;

    always_comb begin
        ld_ext = rd_shifted;
        case (size_q)
            2'd0:    ld_ext = {{24{~uns_q & rd_shifted[7]}},  rd_shifted[7:0]};
            2'd1:    ld_ext = {{16{~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: ld_ext = rd_shifted;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and outputs. All mem_* outputs are zero outside ACCESS, and
    // the response fields are zero outside RESP.
    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        mem_valid  = 1'b0;
        mem_wen    = 1'b0;
        mem_raddr  = 32'h0;
        mem_waddr  = 32'h0;
        mem_wdata  = 32'h0;
        mem_wmask  = 8'h00;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_n = S_RESP;
                    end else if (NO_WAIT) begin
                        state_n = S_ACCESS;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == LAST_CNT) begin
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_valid = 1'b1;
                mem_wen   = wen_q;
                mem_raddr = word_addr;
                mem_waddr = word_addr;
                if (wen_q) begin
                    mem_wdata = lane_wdata;
                    mem_wmask = {4'b0000, lane_mask};
                end
                state_n = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                if (resp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Request latch, wait counter and response data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= 8'd0;
            wen_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wen_q   <= req_wen;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        err_q   <= req_bad;
                        rdata_q <= 32'h0;
                        cnt     <= 8'd0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                end
                S_ACCESS: begin
                    // Stores report zero data; loads take the extended lane.
                    rdata_q <= wen_q ? 32'h0 : ld_ext;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
